// File: rtl/crc8_frame_ctrl.sv
// Frame-level CRC appender: forwards payload bytes through one output register,
// feeds them to an external crc8 core, then emits the CRC byte as the final beat.
module crc8_frame_ctrl #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             s_data_i,
    input  logic                   s_valid_i,
    input  logic                   s_last_i,
    output logic                   s_ready_o,
    output logic [7:0]             m_data_o,
    output logic                   m_valid_o,
    output logic                   m_last_o,
    input  logic                   m_ready_i,
    output logic                   crc_rst_o,
    output logic [7:0]             crc_data_o,
    output logic                   crc_data_valid_o,
    input  logic [7:0]             crc_i,
    output logic [COUNT_WIDTH-1:0] frame_count_o
);

    typedef enum logic [1:0] {
        ST_DATA   = 2'd0,
        ST_APPEND = 2'd1,
        ST_CLEAR  = 2'd2
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [7:0]             m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;
    logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;

    logic slot_free_s;
    logic s_ready_s;
    logic accept_s;

    // Handshake qualifiers; reset blocks acceptance so no byte is taken while the core is cleared.
    always_comb begin
        slot_free_s = !m_valid_q || m_ready_i;
        if (rst_i) begin
            s_ready_s = 1'b0;
        end else begin
            s_ready_s = (state_q == ST_DATA) && slot_free_s;
        end
        accept_s = s_valid_i && s_ready_s;
    end

    // Next-state and output-register update for the DATA -> APPEND -> CLEAR sequence.
    always_comb begin
        state_d       = state_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        frame_count_d = frame_count_q;
        // Default: drain the output register if downstream takes the beat.
        if (m_ready_i) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        case (state_q)
            ST_DATA: begin
                if (accept_s) begin
                    m_data_d  = s_data_i;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    if (s_last_i) begin
                        state_d = ST_APPEND;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_APPEND: begin
                if (slot_free_s) begin
                    m_data_d      = crc_i;
                    m_valid_d     = 1'b1;
                    m_last_d      = 1'b1;
                    frame_count_d = frame_count_q + COUNT_ONE;
                    state_d       = ST_CLEAR;
                end else begin
                    state_d = ST_APPEND;
                end
            end
            ST_CLEAR: begin
                state_d = ST_DATA;
            end
            default: begin
                state_d   = ST_DATA;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_DATA;
            m_data_q      <= 8'h00;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            frame_count_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_last_q      <= m_last_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign s_ready_o        = s_ready_s;
    assign m_data_o         = m_data_q;
    assign m_valid_o        = m_valid_q;
    assign m_last_o         = m_last_q;
    assign crc_rst_o        = rst_i || (state_q == ST_CLEAR);
    assign crc_data_o       = s_data_i;
    assign crc_data_valid_o = accept_s;
    assign frame_count_o    = frame_count_q;

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Scoreboard bench for crc8_frame_ctrl with a behavioural crc8 core alongside it
// and a long-division CRC-8/0x07 reference model.
module tb_crc8_frame_ctrl;

    localparam int CW = 4;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst_i;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic          crc_rst;
    logic [7:0]    crc_data;
    logic          crc_dv;
    logic [7:0]    crc_q;
    logic [CW-1:0] fc;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rst_pulses = 0;
    int n_crc = 0;
    int first_acc_cyc = 0;
    int last_acc_cyc = 0;
    bit rdy_rand = 1'b0;
    bit rdy_force = 1'b1;

    logic [8:0] exp_q[$];
    logic [8:0] e;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    always #5 clk = ~clk;

    crc8_frame_ctrl #(.COUNT_WIDTH(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .s_data_i        (s_data),
        .s_valid_i       (s_valid),
        .s_last_i        (s_last),
        .s_ready_o       (s_ready),
        .m_data_o        (m_data),
        .m_valid_o       (m_valid),
        .m_last_o        (m_last),
        .m_ready_i       (m_ready),
        .crc_rst_o       (crc_rst),
        .crc_data_o      (crc_data),
        .crc_data_valid_o(crc_dv),
        .crc_i           (crc_q),
        .frame_count_o   (fc)
    );

    // External crc8 core: byte-at-a-time update, MSB first, polynomial 0x07
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) begin
            if (r[7]) r = {r[6:0], 1'b0} ^ 8'h07;
            else      r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (crc_rst)     crc_q <= 8'h00;
        else if (crc_dv) crc_q <= crc8_step(crc_q, crc_data);
    end

    // Reference: remainder of M(x)*x^8 divided by x^8+x^2+x+1, by long division over the bit stream
    function automatic logic [7:0] ref_crc(input bq_t msg);
        logic [8:0] r;
        logic       bt;
        r = 9'd0;
        for (int i = 0; i <= msg.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                if (i < msg.size()) bt = msg[i][b];
                else                bt = 1'b0;
                r = {r[7:0], bt};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        return r[7:0];
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) m_ready = ($urandom_range(0, 3) != 0);
        else          m_ready = rdy_force;
    end

    // Monitor: pops the scoreboard on every downstream transfer
    initial forever begin
        @(negedge clk);
        if (rst_i) begin
            exp_q.delete();
            n_crc = 0;
            prev_stall = 1'b0;
        end else begin
            if (crc_rst) rst_pulses++;
            if (prev_stall)
                chk(m_valid && m_data == prev_data && m_last == prev_last, "hold_stable",
                    {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", {m_last, m_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({m_last, m_data} == e, "beat", {m_last, m_data}, e);
                end
                if (m_last) begin
                    n_crc++;
                    chk(int'(fc) == (n_crc % (1 << CW)), "frame_count", fc, n_crc % (1 << CW));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic send_frame(input bq_t bytes, input bit do_last, input bit gaps);
        bit acc;
        int budget;
        int g;
        for (int i = 0; i < bytes.size(); i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    s_last  = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            s_data  = bytes[i];
            s_last  = do_last && (i == bytes.size() - 1);
            s_valid = 1'b1;
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 2000) begin
                @(negedge clk);
                acc = s_ready;
                if (acc) begin
                    exp_q.push_back({1'b0, bytes[i]});
                    if (s_last) exp_q.push_back({1'b1, ref_crc(bytes)});
                    if (i == 0) first_acc_cyc = cyc;
                    last_acc_cyc = cyc;
                end
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) begin
                chk(1'b0, "accept_timeout", budget, 0);
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called right after the last payload byte is accepted: CRC beat is visible one edge later
    task automatic check_crc(input logic [7:0] c, input int fc_exp);
        @(posedge clk);
        #1;
        chk(m_valid && m_last && m_data == c, "crc_beat", {m_valid, m_last, m_data}, {2'b11, c});
        chk(int'(fc) == fc_exp, "frame_count_after_crc", fc, fc_exp);
    endtask

    task automatic drain();
        int budget;
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drain();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        bq_t f;
        int  l1;
        int  rp0;
        logic [7:0] bp_crc;
        rst_i = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(m_valid == 1'b0, "rst_m_valid", m_valid, 0);
        chk(m_last == 1'b0, "rst_m_last", m_last, 0);
        chk(m_data == 8'h00, "rst_m_data", m_data, 0);
        chk(fc == '0, "rst_frame_count", fc, 0);
        chk(crc_rst == 1'b1, "rst_crc_rst", crc_rst, 1);
        rst_i = 1'b0;
        @(negedge clk);
        chk(crc_rst == 1'b0, "idle_crc_rst", crc_rst, 0);
        chk(s_ready == 1'b1, "idle_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        // "123456789" check value
        f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send_frame(f, 1'b1, 1'b0);
        check_crc(8'hF4, 1);

        // Back-to-back single-byte frames
        do_reset();
        rp0 = rst_pulses;
        f = {8'h01};
        send_frame(f, 1'b1, 1'b0);
        l1 = last_acc_cyc;
        check_crc(8'h07, 1);
        f = {8'h00};
        send_frame(f, 1'b1, 1'b0);
        chk(first_acc_cyc - l1 == 3, "s_ready_gap", first_acc_cyc - l1, 3);
        chk(rst_pulses - rp0 == 1, "crc_rst_pulses", rst_pulses - rp0, 1);
        check_crc(8'h00, 2);

        // Backpressure while the CRC beat is pending
        f = {8'h10, 8'h20, 8'h30};
        bp_crc = ref_crc(f);
        send_frame(f, 1'b1, 1'b0);
        @(negedge clk);
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        repeat (5) begin
            @(negedge clk);
            chk(m_valid && m_last && m_data == bp_crc, "bp_crc_hold",
                {m_valid, m_last, m_data}, {2'b11, bp_crc});
            chk(s_ready == 1'b0, "bp_s_ready", s_ready, 0);
        end
        rdy_force = 1'b1;
        drain();

        // Reset mid-frame after three bytes
        do_reset();
        f = {8'hA1, 8'hA2, 8'hA3};
        send_frame(f, 1'b0, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk(m_valid == 1'b0, "abort_m_valid", m_valid, 0);
        chk(fc == '0, "abort_frame_count", fc, 0);
        chk(crc_q == 8'h00, "abort_crc_cleared", crc_q, 0);
        @(posedge clk);
        #1;
        f = {8'hAB};
        send_frame(f, 1'b1, 1'b0);
        check_crc(8'h58, 1);

        // Counter wrap: 17 frames from zero
        do_reset();
        for (int n = 0; n < 17; n++) begin
            f.delete();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) f.push_back(8'($urandom));
            send_frame(f, 1'b1, 1'b0);
        end
        drain();
        chk(int'(fc) == 1, "wrap_count", fc, 1);

        // Randomized frames with random gaps and backpressure
        rdy_rand = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int len;
            len = $urandom_range(1, 64);
            f.delete();
            for (int k = 0; k < len; k++) f.push_back(8'($urandom));
            send_frame(f, 1'b1, 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

endmodule
